// File: rtl/mem_bank_pkg.sv
// mem_bank_pkg: shared definitions for the mem_bank block.
//   - default parameter constants
//   - FSM state enumeration (INIT sweep, IDLE service)
//   - even-parity helper for one byte
package mem_bank_pkg;

  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned ADDR_W_DEF = 8;
  localparam int unsigned DEPTH_DEF  = 256;
  localparam int unsigned RD_LAT_DEF = 1;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_IDLE = 1'b1
  } state_e;

  // Even parity: the stored bit makes the 9-bit group have an even number of ones.
  function automatic logic byte_parity(input logic [7:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/mem_bank_rd_pipe.sv
// mem_bank_rd_pipe: RD_LAT-deep read-return pipeline.
// Ports:
//   clk, rst          clock, asynchronous active-high reset (flushes all stages)
//   vld_i             read accepted this cycle
//   data_i            word read for the accepted request (0 when out of range)
//   err_i             accepted read is out of range
//   perr_i            accepted read failed its parity check
//   err_inj_i         write-side error, surfaces on err one cycle later
//   rd_valid_o        registered read-valid pulse
//   rd_data_o         registered read data, holds when no read returns
//   err_o             registered error pulse
//   par_err_o         registered parity-error pulse, aligned to rd_valid_o
module mem_bank_rd_pipe #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              vld_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              err_i,
  input  logic              perr_i,
  input  logic              err_inj_i,
  output logic              rd_valid_o,
  output logic [DATA_W-1:0] rd_data_o,
  output logic              err_o,
  output logic              par_err_o
);

  logic [RD_LAT-1:0] vld_q, vld_d;
  logic [RD_LAT-1:0] err_q, err_d;
  logic [RD_LAT-1:0] perr_q, perr_d;
  logic [DATA_W-1:0] data_q [RD_LAT];
  logic [DATA_W-1:0] data_d [RD_LAT];

  // Stage advance; data registers only load when a valid entry arrives so the
  // output word holds between reads.
  always_comb begin
    vld_d     = '0;
    err_d     = '0;
    perr_d    = '0;
    vld_d[0]  = vld_i;
    err_d[0]  = vld_i & err_i;
    perr_d[0] = vld_i & perr_i;
    data_d[0] = vld_i ? data_i : data_q[0];
    for (int i = 1; i < RD_LAT; i++) begin
      vld_d[i]  = vld_q[i-1];
      err_d[i]  = err_q[i-1];
      perr_d[i] = perr_q[i-1];
      data_d[i] = vld_q[i-1] ? data_q[i-1] : data_q[i];
    end
    // Write errors bypass earlier stages so they always appear one cycle later.
    err_d[RD_LAT-1] = err_d[RD_LAT-1] | err_inj_i;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q  <= '0;
      err_q  <= '0;
      perr_q <= '0;
      for (int i = 0; i < RD_LAT; i++) data_q[i] <= '0;
    end else begin
      vld_q  <= vld_d;
      err_q  <= err_d;
      perr_q <= perr_d;
      for (int i = 0; i < RD_LAT; i++) data_q[i] <= data_d[i];
    end
  end

  assign rd_valid_o = vld_q[RD_LAT-1];
  assign rd_data_o  = data_q[RD_LAT-1];
  assign err_o      = err_q[RD_LAT-1];
  assign par_err_o  = perr_q[RD_LAT-1];

endmodule

// File: rtl/mem_bank.sv
// mem_bank: single-port word memory with byte strobes, power-up zero sweep,
// range checking and a fixed-latency read return.
// Build option: define MEM_PARITY_EN to store and check one even-parity bit per byte.
// Ports:
//   clk, rst    clock, asynchronous active-high reset
//   ce          chip enable; requests ignored while low
//   rden, wren  read / write request (read wins when both are high)
//   addr        word address
//   be          byte-write strobes
//   wr_data     write data
//   rd_data     read data, holds between reads
//   rd_valid    one-cycle pulse qualifying rd_data, RD_LAT cycles after the read
//   busy        high while the zero sweep runs
//   err         out-of-range pulse (write: next cycle, read: with rd_valid)
//   par_err     parity mismatch pulse with rd_valid (0 without MEM_PARITY_EN)
module mem_bank
  import mem_bank_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DEPTH  = DEPTH_DEF,
  parameter int unsigned RD_LAT = RD_LAT_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ce,
  input  logic                rden,
  input  logic                wren,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [DATA_W/8-1:0] be,
  input  logic [DATA_W-1:0]   wr_data,
  output logic [DATA_W-1:0]   rd_data,
  output logic                rd_valid,
  output logic                busy,
  output logic                err,
  output logic                par_err
);

  localparam int unsigned NB    = DATA_W / 8;
  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] init_addr_q, init_addr_d;
  logic              busy_q, busy_d;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              in_range;
  logic [IDX_W-1:0]  idx;
  logic [IDX_W-1:0]  init_idx;
  logic              rd_acc;
  logic              wr_acc;
  logic              wr_err;
  logic [DATA_W-1:0] rd_word;
  logic              par_chk;

  // Zero sweep walks every word once, then the block serves requests.
  always_comb begin
    state_d     = state_q;
    init_addr_d = init_addr_q;
    case (state_q)
      ST_INIT: begin
        init_addr_d = init_addr_q + ADDR_W'(1);
        if (init_addr_q == ADDR_W'(DEPTH - 1)) begin
          state_d     = ST_IDLE;
          init_addr_d = '0;
        end
      end
      default: ;
    endcase
    busy_d = (state_d == ST_INIT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_INIT;
      init_addr_q <= '0;
      busy_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      init_addr_q <= init_addr_d;
      busy_q      <= busy_d;
    end
  end

  assign busy = busy_q;

  // Request decode; a simultaneous write is dropped in favour of the read.
  assign in_range = (32'(addr) < DEPTH);
  assign idx      = in_range ? IDX_W'(addr) : '0;
  assign init_idx = IDX_W'(init_addr_q);
  assign rd_acc   = (state_q == ST_IDLE) & ce & rden;
  assign wr_acc   = (state_q == ST_IDLE) & ce & wren & ~rden;
  assign wr_err   = wr_acc & ~in_range & (|be);
  assign rd_word  = in_range ? mem[idx] : '0;

  // Storage array: sweep writes zero, otherwise strobed bytes are updated.
  always_ff @(posedge clk) begin
    if (state_q == ST_INIT) begin
      mem[init_idx] <= '0;
    end else if (wr_acc && in_range) begin
      for (int b = 0; b < NB; b++) begin
        if (be[b]) mem[idx][b*8 +: 8] <= wr_data[b*8 +: 8];
      end
    end
  end

`ifdef MEM_PARITY_EN
  logic [NB-1:0] par_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (state_q == ST_INIT) begin
      par_mem[init_idx] <= '0;
    end else if (wr_acc && in_range) begin
      for (int b = 0; b < NB; b++) begin
        if (be[b]) par_mem[idx][b] <= byte_parity(wr_data[b*8 +: 8]);
      end
    end
  end

  // Any byte whose stored parity disagrees with its data flags the read.
  always_comb begin
    par_chk = 1'b0;
    if (in_range) begin
      for (int b = 0; b < NB; b++) begin
        if (par_mem[idx][b] != byte_parity(rd_word[b*8 +: 8])) par_chk = 1'b1;
      end
    end
  end
`else
  assign par_chk = 1'b0;
`endif

  mem_bank_rd_pipe #(
    .DATA_W (DATA_W),
    .RD_LAT (RD_LAT)
  ) u_rd_pipe (
    .clk        (clk),
    .rst        (rst),
    .vld_i      (rd_acc),
    .data_i     (rd_word),
    .err_i      (~in_range),
    .perr_i     (par_chk),
    .err_inj_i  (wr_err),
    .rd_valid_o (rd_valid),
    .rd_data_o  (rd_data),
    .err_o      (err),
    .par_err_o  (par_err)
  );

endmodule

// File: tb/tb_mem_bank.sv
// tb_mem_bank: drives two mem_bank instances from the same stimulus
// (A: DEPTH=256, RD_LAT=1; B: DEPTH=200, RD_LAT=2) and checks every cycle
// against a word-array model with a per-cycle expectation schedule.
module tb_mem_bank;

  localparam int NE = 4096;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ce = 1'b0, rden = 1'b0, wren = 1'b0;
  logic [7:0]  addr = '0;
  logic [3:0]  be = '0;
  logic [31:0] wr_data = '0;

  logic [31:0] rdd [2];
  logic [1:0]  rdv, errs, perr, bsy;

  always #5 clk = ~clk;

  mem_bank dut_a (
    .clk(clk), .rst(rst), .ce(ce), .rden(rden), .wren(wren), .addr(addr),
    .be(be), .wr_data(wr_data), .rd_data(rdd[0]), .rd_valid(rdv[0]),
    .busy(bsy[0]), .err(errs[0]), .par_err(perr[0])
  );

  mem_bank #(.DEPTH(200), .RD_LAT(2)) dut_b (
    .clk(clk), .rst(rst), .ce(ce), .rden(rden), .wren(wren), .addr(addr),
    .be(be), .wr_data(wr_data), .rd_data(rdd[1]), .rd_valid(rdv[1]),
    .busy(bsy[1]), .err(errs[1]), .par_err(perr[1])
  );

  int          dep [2] = '{256, 200};
  int          lat [2] = '{1, 2};
  logic [31:0] mdl [2][256];
  bit          exp_vld [2][NE];
  bit          exp_err [2][NE];
  bit          exp_par [2][NE];
  logic [31:0] exp_dat [2][NE];
  bit          obs_vld [2][NE];
  logic [31:0] obs_dat [2][NE];
  logic [31:0] last [2];
  int          cyc = 0;
  int          rel = 0;
  bit          in_rst = 1'b1;
  int          n_checks = 0;
  int          n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Model of one request for edge n, derived from the behavioural rules.
  task automatic model_req(input int i, input int n, input bit c, input bit r, input bit w,
                           input logic [7:0] a, input logic [3:0] b, input logic [31:0] d);
    bit inr;
    int e;
    if (in_rst || n <= rel + dep[i] || !c || !(r || w)) return;
    inr = (int'(a) < dep[i]);
    if (r) begin
      e = n + lat[i] - 1;
      exp_vld[i][e] = 1'b1;
      exp_dat[i][e] = inr ? mdl[i][a] : 32'h0;
      if (!inr) exp_err[i][e] = 1'b1;
    end else if (b != 4'h0) begin
      if (!inr) exp_err[i][n] = 1'b1;
      else for (int k = 0; k < 4; k++) if (b[k]) mdl[i][a][k*8 +: 8] = d[k*8 +: 8];
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < 2; i++) begin
      if (exp_vld[i][cyc]) last[i] = exp_dat[i][cyc];
      chk($sformatf("rd_valid%0d@%0d", i, cyc), 32'(rdv[i]), 32'(exp_vld[i][cyc]));
      chk($sformatf("rd_data%0d@%0d", i, cyc), rdd[i], last[i]);
      chk($sformatf("err%0d@%0d", i, cyc), 32'(errs[i]), 32'(exp_err[i][cyc]));
      chk($sformatf("par_err%0d@%0d", i, cyc), 32'(perr[i]), 32'(exp_par[i][cyc]));
      chk($sformatf("busy%0d@%0d", i, cyc), 32'(bsy[i]),
          32'(in_rst || (cyc < rel + dep[i])));
      obs_vld[i][cyc] = rdv[i];
      obs_dat[i][cyc] = rdd[i];
    end
  endtask

  task automatic tick(input bit c, input bit r, input bit w, input logic [7:0] a,
                      input logic [3:0] b, input logic [31:0] d);
    if (cyc >= NE - 4) begin
      $display("FAIL cycle_budget observed=%0d expected<%0d", cyc, NE - 4);
      $fatal(1);
    end
    ce = c; rden = r; wren = w; addr = a; be = b; wr_data = d;
    for (int i = 0; i < 2; i++) model_req(i, cyc + 1, c, r, w, a, b, d);
    @(posedge clk);
    cyc++;
    @(negedge clk);
    check_all();
  endtask

  task automatic idle(input int k);
    repeat (k) tick(1'b0, 1'b0, 1'b0, 8'h00, 4'h0, 32'h0);
  endtask

  task automatic do_reset(input int hold);
    rst = 1'b1;
    in_rst = 1'b1;
    #1;
    for (int i = 0; i < 2; i++) begin
      last[i] = 32'h0;
      for (int a = 0; a < 256; a++) mdl[i][a] = 32'h0;
      for (int e = cyc + 1; e < NE; e++) begin
        exp_vld[i][e] = 1'b0; exp_err[i][e] = 1'b0; exp_par[i][e] = 1'b0;
      end
      chk($sformatf("rst_rd_valid%0d", i), 32'(rdv[i]), 32'h0);
      chk($sformatf("rst_rd_data%0d", i), rdd[i], 32'h0);
      chk($sformatf("rst_err%0d", i), 32'(errs[i]), 32'h0);
      chk($sformatf("rst_par_err%0d", i), 32'(perr[i]), 32'h0);
      chk($sformatf("rst_busy%0d", i), 32'(bsy[i]), 32'h1);
    end
    idle(hold);
    rst = 1'b0;
    in_rst = 1'b0;
    rel = cyc;
  endtask

  initial begin
    int n0;
    int busy_len [2];
    bit c, r, w;
    logic [7:0] a;
    logic [3:0] b;

    @(negedge clk);
    do_reset(2);

    // Sweep length: count busy-high cycles from release.
    busy_len[0] = int'(bsy[0]);
    busy_len[1] = int'(bsy[1]);
    for (int k = 0; k < 300; k++) begin
      idle(1);
      busy_len[0] += int'(bsy[0]);
      busy_len[1] += int'(bsy[1]);
    end
    chk("busy_len_a", 32'(busy_len[0]), 32'd256);
    chk("busy_len_b", 32'(busy_len[1]), 32'd200);

    // Fresh memory reads zero.
    tick(1'b1, 1'b1, 1'b0, 8'h10, 4'h0, 32'h0);
    idle(3);
    chk("rd_0x10_a", rdd[0], 32'h0);
    chk("rd_0x10_b", rdd[1], 32'h0);

    // Byte-strobed merge.
    tick(1'b1, 1'b0, 1'b1, 8'h05, 4'hF, 32'hDEADBEEF);
    tick(1'b1, 1'b0, 1'b1, 8'h05, 4'h2, 32'h00001100);
    tick(1'b1, 1'b1, 1'b0, 8'h05, 4'h0, 32'h0);
    idle(3);
    chk("merge_a", rdd[0], 32'hDEAD11EF);
    chk("merge_b", rdd[1], 32'hDEAD11EF);

    // Read wins over a simultaneous write; memory keeps the old word.
    tick(1'b1, 1'b0, 1'b1, 8'h07, 4'hF, 32'hA5A5A5A5);
    tick(1'b1, 1'b1, 1'b1, 8'h07, 4'hF, 32'h12345678);
    tick(1'b1, 1'b1, 1'b0, 8'h07, 4'h0, 32'h0);
    idle(3);
    chk("rd_prio_a", rdd[0], 32'hA5A5A5A5);
    chk("rd_prio_b", rdd[1], 32'hA5A5A5A5);

    // Out-of-range for B (DEPTH=200), in range for A.
    tick(1'b1, 1'b0, 1'b1, 8'hC8, 4'hF, 32'hCAFEF00D);
    chk("wr_oor_err_b", 32'(errs[1]), 32'h1);
    chk("wr_inr_err_a", 32'(errs[0]), 32'h0);
    idle(1);
    tick(1'b1, 1'b1, 1'b0, 8'hC8, 4'h0, 32'h0);
    chk("rd_c8_vld_a", 32'(rdv[0]), 32'h1);
    chk("rd_c8_dat_a", rdd[0], 32'hCAFEF00D);
    idle(1);
    chk("rd_c8_vld_b", 32'(rdv[1]), 32'h1);
    chk("rd_c8_err_b", 32'(errs[1]), 32'h1);
    chk("rd_c8_dat_b", rdd[1], 32'h0);
    idle(2);

    // Back-to-back reads on the two-cycle instance.
    tick(1'b1, 1'b0, 1'b1, 8'h01, 4'hF, 32'h11);
    tick(1'b1, 1'b0, 1'b1, 8'h02, 4'hF, 32'h22);
    tick(1'b1, 1'b0, 1'b1, 8'h03, 4'hF, 32'h33);
    n0 = cyc + 1;
    tick(1'b1, 1'b1, 1'b0, 8'h01, 4'h0, 32'h0);
    tick(1'b1, 1'b1, 1'b0, 8'h02, 4'h0, 32'h0);
    tick(1'b1, 1'b1, 1'b0, 8'h03, 4'h0, 32'h0);
    idle(3);
    chk("b2b_pre", 32'(obs_vld[1][n0]), 32'h0);
    chk("b2b_v1", 32'(obs_vld[1][n0+1]), 32'h1);
    chk("b2b_v2", 32'(obs_vld[1][n0+2]), 32'h1);
    chk("b2b_v3", 32'(obs_vld[1][n0+3]), 32'h1);
    chk("b2b_post", 32'(obs_vld[1][n0+4]), 32'h0);
    chk("b2b_d1", obs_dat[1][n0+1], 32'h11);
    chk("b2b_d2", obs_dat[1][n0+2], 32'h22);
    chk("b2b_d3", obs_dat[1][n0+3], 32'h33);

    // Reset lands while B still has a read in flight, then again mid-sweep.
    tick(1'b1, 1'b1, 1'b0, 8'h01, 4'h0, 32'h0);
    tick(1'b1, 1'b1, 1'b0, 8'h02, 4'h0, 32'h0);
    do_reset(2);
    idle(50);
    do_reset(1);
    idle(260);

`ifdef MEM_PARITY_EN
    // Corrupt one stored parity bit in A; only its read flags par_err.
    tick(1'b1, 1'b0, 1'b1, 8'h09, 4'hF, 32'h0F0F0F0F);
    idle(1);
    dut_a.par_mem[9][0] = ~dut_a.par_mem[9][0];
    exp_par[0][cyc + lat[0]] = 1'b1;
    tick(1'b1, 1'b1, 1'b0, 8'h09, 4'h0, 32'h0);
    chk("par_flip_a", 32'(perr[0]), 32'h1);
    idle(2);
`endif

    // Randomised traffic, addresses biased low to exercise read-after-write.
    for (int k = 0; k < 500; k++) begin
      c = ($urandom_range(0, 7) != 0);
      r = ($urandom_range(0, 2) == 0);
      w = ($urandom_range(0, 1) == 1);
      a = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 15)) : 8'($urandom_range(0, 255));
      b = 4'($urandom);
      if (w && a >= 8'd200 && b == 4'h0) b = 4'h1;
      tick(c, r, w, a, b, $urandom);
    end
    idle(4);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_bank.md
MEM_BANK -- requirements
Module: mem_bank

Interface
REQ-001 Parameter DATA_W, default 32, data width in bits; SHALL be a multiple of 8.
REQ-002 Parameter ADDR_W, default 8, address width in bits.
REQ-003 Parameter DEPTH, default 256, number of words; SHALL satisfy 1 <= DEPTH <= 2**ADDR_W.
REQ-004 Parameter RD_LAT, default 1, read latency in cycles; legal values are 1 and 2 only.
REQ-005 The block SHALL use one clock; reset is asynchronous and active-high.
REQ-006 clk  input  1  rising-edge clock.
REQ-007 rst  input  1  asynchronous active-high reset.
REQ-008 ce  input  1  chip enable; no request is accepted while low.
REQ-009 rden  input  1  read request.
REQ-010 wren  input  1  write request.
REQ-011 addr  input  ADDR_W  word address.
REQ-012 be  input  DATA_W/8  byte-write strobes.
REQ-013 wr_data  input  DATA_W  write data.
REQ-014 rd_data  output  DATA_W  read data.
REQ-015 rd_valid  output  1  one-cycle pulse qualifying rd_data.
REQ-016 busy  output  1  high while the initialisation sweep runs.
REQ-017 err  output  1  one-cycle pulse flagging an out-of-range access.
REQ-018 par_err  output  1  one-cycle parity-error pulse aligned to rd_valid.

Function
REQ-019 FSM states are INIT and IDLE; INIT SHALL zero word 0..DEPTH-1, one word per cycle, then go to IDLE; busy SHALL be 1 exactly while in INIT (DEPTH cycles).
REQ-020 Requests in INIT SHALL be ignored: no write, no rd_valid, no err.
REQ-021 A request is accepted in IDLE when ce=1 and rden or wren is 1; rden SHALL take priority over wren when both are high, and the write SHALL be dropped.
REQ-022 An accepted read SHALL assert rd_valid with data exactly RD_LAT cycles later; back-to-back reads SHALL sustain one per cycle.
REQ-023 rd_data SHALL hold its last value when rd_valid is 0.
REQ-024 A write SHALL update only the bytes whose be bit is 1 at the next edge; be=0 is a no-op with no err.
REQ-025 An address >= DEPTH SHALL be out of range: the write is dropped and err pulses the next cycle; a read returns 0 with err pulsing together with its rd_valid.
REQ-026 A read issued the cycle after a write to the same address SHALL return the new data.

Reset
REQ-027 On rst: rd_data=0, rd_valid=0, err=0, par_err=0, busy=1, the read pipeline is flushed, and the FSM enters INIT at word 0.
REQ-028 rst asserted mid-INIT or mid-read SHALL restart INIT from word 0; in-flight reads SHALL be discarded without a rd_valid pulse.

Configuration
REQ-029 With MEM_PARITY_EN defined, one even-parity bit per byte SHALL be stored on write (per strobed byte) and checked on read; a mismatch SHALL set par_err with rd_valid; INIT SHALL write zero parity.
REQ-030 Without MEM_PARITY_EN, no parity storage SHALL exist and par_err SHALL be tied to 0.

Structure
REQ-031 Package mem_bank_pkg SHALL hold the FSM state enum (INIT, IDLE), the default parameter constants and the byte-parity function.
REQ-032 Sub-module mem_bank_rd_pipe SHALL implement the RD_LAT-deep data/valid/err/par_err pipeline.

Verification
REQ-033 Reset release, DEPTH=256 -> busy high exactly 256 cycles; a read of addr 0x10 after that returns 0x00000000.
REQ-034 Write 0xDEADBEEF to 0x05 with be=4'b1111, then with be=4'b0010 write 0x00001100 -> read returns 0xDEAD11EF after RD_LAT cycles.
REQ-035 ce=1, rden=1 and wren=1 together at 0x07 (data 0x12345678) -> old value is returned and memory is unchanged.
REQ-036 DEPTH=200, write to 0xC8 -> err pulses the next cycle; read of 0xC8 -> rd_data=0, err=1 and rd_valid=1.
REQ-037 RD_LAT=2, reads of 0x01, 0x02, 0x03 on consecutive cycles -> three consecutive rd_valid pulses in order; rst asserted after the second read -> no further rd_valid, and busy rises.
REQ-038 With MEM_PARITY_EN, a forced stored parity bit is flipped at 0x09 -> the read sets par_err=1 with rd_valid.
